// File: rtl/exu_load_seq.sv
// exu_load_seq: multi-cycle RV32I load sequencer for the execute stage.
// Computes the effective address and runs one bus read per load. It then
// extracts and extends the addressed lane and retires with a GPR write or
// an exception pulse.
module exu_load_seq #(
    parameter int XLEN   = 32,
    parameter int GPR_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iexec_req_vld,
    input  logic              is_load,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   imm,
    input  logic [GPR_AW-1:0] rd,
    output logic              iexec_req_rdy,
    output logic              ldst_req_vld,
    input  logic              ldst_req_rdy,
    output logic [XLEN-1:0]   ldst_req_addr,
    input  logic              ldst_rsp_vld,
    output logic              ldst_rsp_rdy,
    input  logic [XLEN-1:0]   ldst_rsp_data,
    input  logic              ldst_rsp_err,
    output logic              gpr_wen,
    output logic [GPR_AW-1:0] gpr_waddr,
    output logic [XLEN-1:0]   gpr_wdata,
    output logic              exc_vld,
    output logic [1:0]        exc_cause
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_MISALGN = 2'b01;
    localparam logic [1:0] CAUSE_FAULT   = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [GPR_AW-1:0]   rd_q, rd_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          cause_q, cause_d;

    logic [XLEN-1:0]     ea;
    logic                illegal;
    logic                misaligned;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;
    logic [XLEN-1:0]     lane_ext;

    assign ea = rs1_data + imm;

    // Decode checks on the incoming load; illegal funct3 takes precedence.
    always_comb begin
        illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        misaligned = ((funct3[1:0] == 2'b01) && ea[0]) ||
                     ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    end

    // Select the addressed byte/half of the returned word and extend it.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = ldst_rsp_data[7:0];
            2'd1:    lane_b = ldst_rsp_data[15:8];
            2'd2:    lane_b = ldst_rsp_data[23:16];
            default: lane_b = ldst_rsp_data[31:24];
        endcase
        lane_h = addr_q[1] ? ldst_rsp_data[31:16] : ldst_rsp_data[15:0];
        case (f3_q[1:0])
            2'b00:   lane_ext = {{(XLEN-8){lane_b[7] & ~f3_q[2]}}, lane_b};
            2'b01:   lane_ext = {{(XLEN-16){lane_h[15] & ~f3_q[2]}}, lane_h};
            default: lane_ext = ldst_rsp_data;
        endcase
    end

    // Next-state and output logic; every output is idle unless its state drives it.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        rd_d          = rd_q;
        f3_d          = f3_q;
        cause_d       = cause_q;
        iexec_req_rdy = 1'b0;
        ldst_req_vld  = 1'b0;
        ldst_req_addr = '0;
        ldst_rsp_rdy  = 1'b0;
        gpr_wen       = 1'b0;
        gpr_waddr     = '0;
        gpr_wdata     = '0;
        exc_vld       = 1'b0;
        exc_cause     = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (iexec_req_vld && is_load) begin
                    addr_d = ea;
                    rd_d   = rd;
                    f3_d   = funct3;
                    data_d = '0;
                    if (illegal) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = S_WB;
                    end else if (misaligned) begin
                        cause_d = CAUSE_MISALGN;
                        state_d = S_WB;
                    end else begin
                        cause_d = CAUSE_NONE;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                ldst_req_vld  = 1'b1;
                ldst_req_addr = {addr_q[XLEN-1:2], 2'b00};
                if (ldst_req_rdy) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                ldst_rsp_rdy = 1'b1;
                if (ldst_rsp_vld) begin
                    data_d  = lane_ext;
                    cause_d = ldst_rsp_err ? CAUSE_FAULT : CAUSE_NONE;
                    state_d = S_WB;
                end
            end
            default: begin
                iexec_req_rdy = 1'b1;
                gpr_waddr     = rd_q;
                gpr_wdata     = data_q;
                gpr_wen       = (cause_q == CAUSE_NONE) && (rd_q != '0);
                exc_vld       = (cause_q != CAUSE_NONE);
                exc_cause     = cause_q;
                state_d       = S_IDLE;
            end
        endcase
    end

    // State and captured load context; synchronous active-low reset clears all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_exu_load_seq.sv
// tb_exu_load_seq: table-driven loads with a small bus model and a scoreboard
// of expected retirements, plus reset and non-load sequences.
module tb_exu_load_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iexec_req_vld;
    logic        is_load;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        iexec_req_rdy;
    logic        ldst_req_vld;
    logic        ldst_req_rdy;
    logic [31:0] ldst_req_addr;
    logic        ldst_rsp_vld;
    logic        ldst_rsp_rdy;
    logic [31:0] ldst_rsp_data;
    logic        ldst_rsp_err;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        exc_vld;
    logic [1:0]  exc_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exu_load_seq #(.XLEN(32), .GPR_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .iexec_req_vld(iexec_req_vld), .is_load(is_load), .funct3(funct3),
        .rs1_data(rs1_data), .imm(imm), .rd(rd),
        .iexec_req_rdy(iexec_req_rdy),
        .ldst_req_vld(ldst_req_vld), .ldst_req_rdy(ldst_req_rdy),
        .ldst_req_addr(ldst_req_addr),
        .ldst_rsp_vld(ldst_rsp_vld), .ldst_rsp_rdy(ldst_rsp_rdy),
        .ldst_rsp_data(ldst_rsp_data), .ldst_rsp_err(ldst_rsp_err),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .exc_vld(exc_vld), .exc_cause(exc_cause)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
        int          req_wait;
        int          rsp_wait;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_cause;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] rs1,
                                input logic [31:0] im, input logic [4:0] r,
                                input logic [31:0] rdata, input logic err,
                                input int rqw, input int rsw, input logic ereq,
                                input logic [31:0] eaddr, input logic ewen,
                                input logic [31:0] ewd, input logic [1:0] ecause);
        vec_t v;
        v.f3 = f3; v.rs1 = rs1; v.imm = im; v.rd = r; v.rdata = rdata; v.err = err;
        v.req_wait = rqw; v.rsp_wait = rsw; v.exp_req = ereq; v.exp_addr = eaddr;
        v.exp_wen = ewen; v.exp_wdata = ewd; v.exp_cause = ecause;
        v.exp_lat = ereq ? (3 + rqw + rsw) : 1;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},   {31'd0, iexec_req_rdy}, 32'd0);
        chk({tag, "_reqv"},  {31'd0, ldst_req_vld},  32'd0);
        chk({tag, "_addr"},  ldst_req_addr,          32'd0);
        chk({tag, "_rsprdy"},{31'd0, ldst_rsp_rdy},  32'd0);
        chk({tag, "_wen"},   {31'd0, gpr_wen},       32'd0);
        chk({tag, "_waddr"}, {27'd0, gpr_waddr},     32'd0);
        chk({tag, "_wdata"}, gpr_wdata,              32'd0);
        chk({tag, "_exc"},   {29'd0, exc_vld, exc_cause}, 32'd0);
    endtask

    // Drive one load, act as the bus, and compare the retirement against the scoreboard.
    task automatic do_load(input int idx, input vec_t v);
        int   cyc;
        int   rq;
        int   rs;
        bit   done;
        bit   saw_req;
        vec_t e;
        @(negedge clk);
        iexec_req_vld = 1'b1; is_load = 1'b1; funct3 = v.f3;
        rs1_data = v.rs1; imm = v.imm; rd = v.rd;
        sb.push_back(v);
        cyc = 0; rq = 0; rs = 0; done = 0; saw_req = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            ldst_req_rdy = 1'b0; ldst_rsp_vld = 1'b0;
            ldst_rsp_data = 32'd0; ldst_rsp_err = 1'b0;
            if (ldst_req_vld) begin
                saw_req = 1;
                chk($sformatf("v%0d_req_addr", idx), ldst_req_addr, v.exp_addr);
                ldst_req_rdy = (rq >= v.req_wait);
                rq++;
            end
            if (ldst_rsp_rdy) begin
                if (rs >= v.rsp_wait) begin
                    ldst_rsp_vld = 1'b1; ldst_rsp_data = v.rdata; ldst_rsp_err = v.err;
                end
                rs++;
            end
            if (iexec_req_rdy) begin
                done = 1;
                iexec_req_vld = 1'b0; is_load = 1'b0;
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d_sb_empty", idx), 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d_issued_req", idx), {31'd0, saw_req}, {31'd0, e.exp_req});
                    chk($sformatf("v%0d_latency", idx), cyc, e.exp_lat);
                    chk($sformatf("v%0d_wen", idx), {31'd0, gpr_wen}, {31'd0, e.exp_wen});
                    chk($sformatf("v%0d_exc_vld", idx), {31'd0, exc_vld},
                        {31'd0, (e.exp_cause != 2'b00)});
                    chk($sformatf("v%0d_cause", idx), {30'd0, exc_cause}, {30'd0, e.exp_cause});
                    if (e.exp_wen) begin
                        chk($sformatf("v%0d_waddr", idx), {27'd0, gpr_waddr}, {27'd0, e.rd});
                        chk($sformatf("v%0d_wdata", idx), gpr_wdata, e.exp_wdata);
                    end
                    $display("load %0d f3=%b ea=%h lat=%0d wen=%b wdata=%h cause=%b",
                             idx, v.f3, v.rs1 + v.imm, cyc, gpr_wen, gpr_wdata, exc_cause);
                end
            end
        end
        if (!done) begin
            chk($sformatf("v%0d_timeout", idx), 32'd1, 32'd0);
            iexec_req_vld = 1'b0; is_load = 1'b0;
            void'(sb.pop_front());
        end
        ldst_req_rdy = 1'b0; ldst_rsp_vld = 1'b0;
        ldst_rsp_data = 32'd0; ldst_rsp_err = 1'b0;
    endtask

    initial begin
        int n;
        //            f3      rs1           imm           rd     rdata         err rqw rsw req addr          wen wdata         cause
        vecs[0]  = mk(3'b010, 32'h0000_1000, 32'h0000_0004, 5'd5,  32'hDEAD_BEEF, 0, 0, 0, 1, 32'h0000_1004, 1, 32'hDEAD_BEEF, 2'b00);
        vecs[1]  = mk(3'b000, 32'h0000_2000, 32'h0000_0003, 5'd6,  32'h8012_3456, 0, 0, 0, 1, 32'h0000_2000, 1, 32'hFFFF_FF80, 2'b00);
        vecs[2]  = mk(3'b100, 32'h0000_2000, 32'h0000_0003, 5'd6,  32'h8012_3456, 0, 0, 0, 1, 32'h0000_2000, 1, 32'h0000_0080, 2'b00);
        vecs[3]  = mk(3'b101, 32'h0000_2000, 32'h0000_0002, 5'd7,  32'h8012_3456, 0, 0, 0, 1, 32'h0000_2000, 1, 32'h0000_8012, 2'b00);
        vecs[4]  = mk(3'b010, 32'h0000_3004, 32'hFFFF_FFFE, 5'd8,  32'h0,         0, 0, 0, 0, 32'h0,         0, 32'h0,         2'b01);
        vecs[5]  = mk(3'b010, 32'h0000_4000, 32'h0000_0008, 5'd9,  32'h1234_5678, 0, 3, 2, 1, 32'h0000_4008, 1, 32'h1234_5678, 2'b00);
        vecs[6]  = mk(3'b010, 32'h0000_0100, 32'h0000_0000, 5'd3,  32'h5555_AAAA, 1, 0, 0, 1, 32'h0000_0100, 0, 32'h0,         2'b10);
        vecs[7]  = mk(3'b010, 32'h0000_0200, 32'h0000_0004, 5'd0,  32'h7777_7777, 0, 0, 0, 1, 32'h0000_0204, 0, 32'h0,         2'b00);
        vecs[8]  = mk(3'b001, 32'h0000_5000, 32'h0000_0001, 5'd4,  32'h0,         0, 0, 0, 0, 32'h0,         0, 32'h0,         2'b01);
        vecs[9]  = mk(3'b011, 32'h0000_0010, 32'h0000_0000, 5'd4,  32'h0,         0, 0, 0, 0, 32'h0,         0, 32'h0,         2'b11);
        vecs[10] = mk(3'b001, 32'h0000_6000, 32'h0000_0000, 5'd10, 32'h1234_F00D, 0, 0, 0, 1, 32'h0000_6000, 1, 32'hFFFF_F00D, 2'b00);
        vecs[11] = mk(3'b000, 32'h0000_7000, 32'h0000_0001, 5'd11, 32'h0000_7F00, 0, 0, 0, 1, 32'h0000_7000, 1, 32'h0000_007F, 2'b00);
        vecs[12] = mk(3'b101, 32'h0000_2000, 32'h0000_0002, 5'd31, 32'h8012_3456, 0, 1, 1, 1, 32'h0000_2000, 1, 32'h0000_8012, 2'b00);

        rst_n = 1'b0; iexec_req_vld = 1'b0; is_load = 1'b0; funct3 = 3'b0;
        rs1_data = 32'd0; imm = 32'd0; rd = 5'd0;
        ldst_req_rdy = 1'b0; ldst_rsp_vld = 1'b0; ldst_rsp_data = 32'd0; ldst_rsp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Non-load instruction with a stray response: must be ignored.
        iexec_req_vld = 1'b1; is_load = 1'b0; funct3 = 3'b010; rs1_data = 32'h100;
        ldst_rsp_vld = 1'b1; ldst_rsp_data = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            chk_all_zero("nonload");
        end
        iexec_req_vld = 1'b0; ldst_rsp_vld = 1'b0; ldst_rsp_data = 32'd0;

        for (int i = 0; i < 13; i++) begin
            do_load(i, vecs[i]);
        end

        // Reset asserted while waiting in RSP; the response never arrives.
        @(negedge clk);
        iexec_req_vld = 1'b1; is_load = 1'b1; funct3 = 3'b010;
        rs1_data = 32'h0000_8000; imm = 32'h0000_0010; rd = 5'd12;
        n = 0;
        while (!ldst_rsp_rdy && n < 20) begin
            @(negedge clk);
            ldst_req_rdy = ldst_req_vld;
            n++;
        end
        chk("rst_reach_rsp", {31'd0, ldst_rsp_rdy}, 32'd1);
        ldst_req_rdy = 1'b0; rst_n = 1'b0;
        iexec_req_vld = 1'b0; is_load = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        $display("reset in RSP: outputs cleared");
        rst_n = 1'b1;
        do_load(13, mk(3'b010, 32'h0000_8000, 32'h0000_0010, 5'd12, 32'hCAFE_F00D,
                       0, 0, 0, 1, 32'h0000_8010, 1, 32'hCAFE_F00D, 2'b00));

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
